// File: rtl/aes_job_feeder.sv
// AES job feeder: key load, priming job, keygen wait, FIFO-fed streaming and drain/halt on key change.
// Optional issued-job counter enabled by defining AES_FEEDER_JOBCNT_EN.
package aes_job_feeder_pkg;
  typedef enum logic [1:0] {
    INVALID = 2'd0,
    ENCRYPT = 2'd1,
    DECRYPT = 2'd2
  } job_t;
endpackage

module aes_job_feeder
  import aes_job_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int KEYGEN_WAIT  = 11,
  parameter int DRAIN_CYCLES = 11
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  input  logic [127:0]                key_in,
  output logic                        key_ready,
  input  logic                        job_valid,
  input  logic                        job_op,
  input  logic [127:0]                job_data,
  output logic                        job_ready,
  output job_t                        eng_in_type,
  output logic [127:0]                eng_state,
  output logic                        eng_set_key,
  output logic [127:0]                eng_key,
  output logic                        eng_halt,
  output logic                        eng_prime,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [31:0]                 jobs_issued
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, LOAD, PRIME, WAIT, RUN, DRAIN, HALT} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [127:0]    key_n;
  job_t            type_n;
  logic [127:0]    data_n;
  logic            set_key_n, halt_n, prime_n;

  logic [128:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            full, empty, push, pop, key_hs;

  assign full       = (count == (AW+1)'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign job_ready  = !full && (state inside {LOAD, PRIME, WAIT, RUN});
  assign key_ready  = (state == IDLE) || ((state == RUN) && empty);
  assign push       = job_valid && job_ready;
  assign pop        = (state == RUN) && !empty;
  assign key_hs     = key_valid && key_ready;
  assign busy       = !((state == IDLE) || (state == RUN));
  assign fifo_count = count;

  // Engine outputs are registered from the current state, so each appears the cycle after its state.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    key_n     = eng_key;
    type_n    = INVALID;
    data_n    = '0;
    set_key_n = 1'b0;
    halt_n    = 1'b0;
    prime_n   = 1'b0;
    case (state)
      IDLE: begin
        if (key_hs) begin
          key_n   = key_in;
          state_n = LOAD;
        end
      end
      LOAD: begin
        set_key_n = 1'b1;
        state_n   = PRIME;
      end
      PRIME: begin
        type_n  = ENCRYPT;
        prime_n = 1'b1;
        cnt_n   = CW'(KEYGEN_WAIT - 1);
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_n = RUN;
        else           cnt_n   = cnt - 1'b1;
      end
      RUN: begin
        if (pop) begin
          type_n = mem[rd_ptr][128] ? DECRYPT : ENCRYPT;
          data_n = mem[rd_ptr][127:0];
        end
        if (key_hs) begin
          key_n   = key_in;
          cnt_n   = CW'(DRAIN_CYCLES - 1);
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_n = HALT;
        else           cnt_n   = cnt - 1'b1;
      end
      HALT: begin
        halt_n  = 1'b1;
        state_n = LOAD;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      eng_key     <= '0;
      eng_in_type <= INVALID;
      eng_state   <= '0;
      eng_set_key <= 1'b0;
      eng_halt    <= 1'b0;
      eng_prime   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      eng_key     <= key_n;
      eng_in_type <= type_n;
      eng_state   <= data_n;
      eng_set_key <= set_key_n;
      eng_halt    <= halt_n;
      eng_prime   <= prime_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {job_op, job_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef AES_FEEDER_JOBCNT_EN
  logic [31:0] job_cnt;
  always_ff @(posedge clk) begin
    if (rst)      job_cnt <= '0;
    else if (pop) job_cnt <= job_cnt + 32'd1;
  end
  assign jobs_issued = job_cnt;
`else
  assign jobs_issued = '0;
`endif

endmodule

// File: tb/tb_aes_job_feeder.sv
// Directed bench for aes_job_feeder: table-driven key load / FIFO streaming, then key change and reset sequences.
module tb_aes_job_feeder;
  import aes_job_feeder_pkg::*;

`ifdef AES_FEEDER_JOBCNT_EN
  localparam int JOBCNT_ON = 1;
`else
  localparam int JOBCNT_ON = 0;
`endif

  logic         clk = 1'b0;
  logic         rst, key_valid, job_valid, job_op;
  logic [127:0] key_in, job_data;
  logic         key_ready, job_ready, eng_set_key, eng_halt, eng_prime, busy;
  job_t         eng_in_type;
  logic [127:0] eng_state, eng_key;
  logic [2:0]   fifo_count;
  logic [31:0]  jobs_issued;

  always #5 clk = ~clk;

  aes_job_feeder #(.FIFO_DEPTH(4), .KEYGEN_WAIT(11), .DRAIN_CYCLES(11)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
    .job_valid(job_valid), .job_op(job_op), .job_data(job_data), .job_ready(job_ready),
    .eng_in_type(eng_in_type), .eng_state(eng_state), .eng_set_key(eng_set_key),
    .eng_key(eng_key), .eng_halt(eng_halt), .eng_prime(eng_prime),
    .busy(busy), .fifo_count(fifo_count), .jobs_issued(jobs_issued)
  );

  typedef struct {
    logic         kv;
    logic [127:0] key;
    logic         jv;
    logic         op;
    logic [127:0] data;
    logic         e_kr, e_jr, e_sk, e_halt, e_prime, e_busy;
    job_t         e_type;
    logic [127:0] e_state, e_key;
    int           e_cnt;
  } vec_t;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KONE = '1;

  vec_t         vecs[$];
  vec_t         v;
  int           checks = 0;
  int           errors = 0;
  logic         jop  [7];
  logic [127:0] jdat [7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t blank(input logic [127:0] ekey);
    vec_t r;
    r.kv = 1'b0; r.key = '0; r.jv = 1'b0; r.op = 1'b0; r.data = '0;
    r.e_kr = 1'b0; r.e_jr = 1'b0; r.e_sk = 1'b0; r.e_halt = 1'b0;
    r.e_prime = 1'b0; r.e_busy = 1'b0; r.e_type = INVALID;
    r.e_state = '0; r.e_key = ekey; r.e_cnt = 0;
    return r;
  endfunction

  function automatic job_t op_type(input logic op);
    return op ? DECRYPT : ENCRYPT;
  endfunction

  // Drive job i into the row; expected outputs are set by the caller.
  function automatic vec_t with_job(input vec_t r, input int i);
    vec_t o = r;
    o.jv = 1'b1; o.op = jop[i]; o.data = jdat[i];
    return o;
  endfunction

  task automatic check_row(input int i, input vec_t r);
    chk($sformatf("r%0d.key_ready", i), 128'(key_ready), 128'(r.e_kr));
    chk($sformatf("r%0d.job_ready", i), 128'(job_ready), 128'(r.e_jr));
    chk($sformatf("r%0d.type", i), 128'(eng_in_type), 128'(r.e_type));
    chk($sformatf("r%0d.state", i), eng_state, r.e_state);
    chk($sformatf("r%0d.set_key", i), 128'(eng_set_key), 128'(r.e_sk));
    chk($sformatf("r%0d.halt", i), 128'(eng_halt), 128'(r.e_halt));
    chk($sformatf("r%0d.prime", i), 128'(eng_prime), 128'(r.e_prime));
    chk($sformatf("r%0d.busy", i), 128'(busy), 128'(r.e_busy));
    chk($sformatf("r%0d.count", i), 128'(fifo_count), 128'(r.e_cnt));
    chk($sformatf("r%0d.key", i), eng_key, r.e_key);
  endtask

  task automatic run_row(input vec_t r);
    v = r;
    vecs.push_back(v);
  endtask

  initial begin
    jop = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) jdat[i] = {4{32'hCAFE0000 + 32'(i)}};

    // r0: after reset, offer K1
    v = blank('0); v.e_kr = 1'b1; v.kv = 1'b1; v.key = K1; run_row(v);
    // r1: LOAD
    v = blank(K1); v.e_jr = 1'b1; v.e_busy = 1'b1; run_row(v);
    // r2: PRIME state, set_key pulse visible
    v = blank(K1); v.e_jr = 1'b1; v.e_busy = 1'b1; v.e_sk = 1'b1; run_row(v);
    // r3..r6: WAIT, priming job visible at r3, jobs 0..3 accepted
    for (int i = 0; i < 4; i++) begin
      v = blank(K1); v.e_jr = 1'b1; v.e_busy = 1'b1; v.e_cnt = i;
      if (i == 0) begin v.e_type = ENCRYPT; v.e_prime = 1'b1; end
      run_row(with_job(v, i));
    end
    // r7..r13: FIFO full, job 4 held
    for (int i = 0; i < 7; i++) begin
      v = blank(K1); v.e_busy = 1'b1; v.e_cnt = 4; run_row(with_job(v, 4));
    end
    // r14: first RUN cycle
    v = blank(K1); v.e_cnt = 4; run_row(with_job(v, 4));
    // r15..r20: jobs 0..5 issued back to back
    for (int i = 0; i < 6; i++) begin
      v = blank(K1);
      v.e_type = op_type(jop[i]); v.e_state = jdat[i];
      v.e_cnt = (i < 3) ? 3 : 5 - i;
      v.e_jr = 1'b1; v.e_kr = (i == 5);
      if (i == 0) v = with_job(v, 4);
      if (i == 1) v = with_job(v, 5);
      if (i == 5) v.e_kr = 1'b1;
      run_row(v);
    end
    // r21..r23: a job into an empty FIFO is not bypassed
    v = blank(K1); v.e_kr = 1'b1; v.e_jr = 1'b1; run_row(with_job(v, 6));
    v = blank(K1); v.e_jr = 1'b1; v.e_cnt = 1; run_row(v);
    v = blank(K1); v.e_kr = 1'b1; v.e_jr = 1'b1;
    v.e_type = op_type(jop[6]); v.e_state = jdat[6]; run_row(v);

    rst = 1'b1; key_valid = 1'b0; key_in = '0; job_valid = 1'b0; job_op = 1'b0; job_data = '0;
    tick(); tick();
    rst = 1'b0;

    foreach (vecs[i]) begin
      check_row(i, vecs[i]);
      key_valid = vecs[i].kv; key_in = vecs[i].key;
      job_valid = vecs[i].jv; job_op = vecs[i].op; job_data = vecs[i].data;
      tick();
    end
    chk("jobs_issued_after_7", 128'(jobs_issued), 128'(JOBCNT_ON * 7));

    // Key change in RUN with empty FIFO; a second key offer during drain must be ignored
    key_valid = 1'b1; key_in = KONE;
    tick();
    key_in = K1;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("drain%0d.type", i), 128'(eng_in_type), 128'(INVALID));
      chk($sformatf("drain%0d.halt", i), 128'(eng_halt), 128'd0);
      chk($sformatf("drain%0d.key_ready", i), 128'(key_ready), 128'd0);
      chk($sformatf("drain%0d.busy", i), 128'(busy), 128'd1);
      tick();
    end
    key_valid = 1'b0;
    chk("halt_pulse", 128'(eng_halt), 128'd1);
    chk("halt_set_key", 128'(eng_set_key), 128'd0);
    chk("new_key", eng_key, KONE);
    tick();
    chk("reload_set_key", 128'(eng_set_key), 128'd1);
    chk("reload_halt_off", 128'(eng_halt), 128'd0);
    tick();
    chk("reprime_prime", 128'(eng_prime), 128'd1);
    chk("reprime_type", 128'(eng_in_type), 128'(ENCRYPT));
    chk("reprime_state", eng_state, 128'd0);

    // Fill FIFO during WAIT, then reset in RUN with three jobs queued
    for (int i = 0; i < 4; i++) begin
      job_valid = 1'b1; job_op = jop[i]; job_data = jdat[i];
      tick();
    end
    job_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("run1_count", 128'(fifo_count), 128'd4);
    chk("run1_busy", 128'(busy), 128'd0);
    tick();
    chk("run2_count", 128'(fifo_count), 128'd3);
    chk("run2_type", 128'(eng_in_type), 128'(op_type(jop[0])));
    chk("run2_state", eng_state, jdat[0]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_count", 128'(fifo_count), 128'd0);
    chk("rst_type", 128'(eng_in_type), 128'(INVALID));
    chk("rst_state", eng_state, 128'd0);
    chk("rst_key", eng_key, 128'd0);
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_job_ready", 128'(job_ready), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_halt", 128'(eng_halt), 128'd0);
    chk("rst_jobs_issued", 128'(jobs_issued), 128'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst%0d.type", i), 128'(eng_in_type), 128'(INVALID));
      chk($sformatf("post_rst%0d.halt", i), 128'(eng_halt), 128'd0);
      chk($sformatf("post_rst%0d.count", i), 128'(fifo_count), 128'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_job_feeder.md
AES_JOB_FEEDER -- requirements
Module: aes_job_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, job queue entries (power of two, 2..16).
REQ-002 SHALL have parameter KEYGEN_WAIT, default 11, cycles held after the priming job before streaming starts.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 11, engine pipeline depth flushed before a key change.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  host key offer
- key_in  in  128  host key
- key_ready  out  1  key accepted when key_valid&key_ready
- job_valid  in  1  host job offer
- job_op  in  1  0=encrypt, 1=decrypt
- job_data  in  128  plaintext or ciphertext block
- job_ready  out  1  job accepted when job_valid&job_ready
- eng_in_type  out  job_t  INVALID/ENCRYPT/DECRYPT to the engine
- eng_state  out  128  block to the engine
- eng_set_key  out  1  key-load pulse to the engine
- eng_key  out  128  key to the engine
- eng_halt  out  1  engine halt pulse
- eng_prime  out  1  marks the priming job; downstream discards its result
- busy  out  1  state is not IDLE or RUN
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued jobs
- jobs_issued  out  32  issued-job counter (see Configuration)

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, PRIME, WAIT, RUN, DRAIN, HALT.
REQ-006 IDLE: key_ready=1; on key handshake, latch key_in into eng_key and go to LOAD.
REQ-007 LOAD: eng_set_key=1 for exactly one cycle; next state PRIME.
REQ-008 PRIME: eng_in_type=ENCRYPT, eng_state=0, eng_prime=1 for one cycle; next state WAIT with the wait counter loaded to KEYGEN_WAIT-1.
REQ-009 WAIT: eng_in_type=INVALID; decrement each cycle; go to RUN on the cycle the counter equals 0.
REQ-010 RUN: when FIFO is non-empty, pop one entry per cycle and drive eng_in_type=ENCRYPT (op 0) or DECRYPT (op 1) with eng_state=data; when empty, drive INVALID.
REQ-011 RUN: key_ready=1 only when the FIFO is empty; a key handshake latches the new key and enters DRAIN with the counter loaded to DRAIN_CYCLES-1.
REQ-012 DRAIN: drive INVALID; count to 0, then go to HALT.
REQ-013 HALT: eng_halt=1 for exactly one cycle; next state LOAD.
REQ-014 eng_in_type, eng_state, eng_set_key, eng_halt and eng_prime SHALL be registered; all other outputs may be combinational from registers.
REQ-015 job_ready SHALL be 1 only when FIFO is not full and state is LOAD, PRIME, WAIT or RUN.
REQ-016 The FIFO SHALL be FIFO order, with no bypass; a job accepted at edge t SHALL be issued at the earliest at edge t+1, visible on eng_* after that edge.
REQ-017 Simultaneous push and pop in RUN SHALL leave fifo_count unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 key_ready SHALL be 0 in LOAD, PRIME, WAIT, DRAIN and HALT; key_valid there SHALL be ignored.
REQ-019 When the engine is idle, eng_state SHALL be 0 while eng_in_type is INVALID.

Reset
REQ-020 rst high at a rising edge SHALL force IDLE, empty the FIFO, and clear the counters.
REQ-021 On that edge, outputs SHALL reset to: eng_in_type=INVALID, eng_state=0, eng_key=0, eng_set_key=0, eng_halt=0, eng_prime=0, jobs_issued=0.
REQ-022 rst mid-operation SHALL discard queued and latched data, with no halt pulse issued.

Configuration
REQ-023 With AES_FEEDER_JOBCNT_EN defined, jobs_issued SHALL increment by 1 per ENCRYPT/DECRYPT issued in RUN, excluding the priming job, and wrap at 2^32.
REQ-024 Without AES_FEEDER_JOBCNT_EN, jobs_issued SHALL be tied to 0 and no counter logic SHALL be instantiated.

Verification
REQ-025 Reset asserted 2 cycles -> eng_in_type=INVALID, all eng_* 0, key_ready=1, job_ready=0, fifo_count=0.
REQ-026 Key 0x000102030405060708090a0b0c0d0e0f offered in IDLE -> eng_set_key=1 one cycle with that eng_key; next cycle ENCRYPT, state 0, eng_prime=1; then 11 cycles INVALID; then RUN.
REQ-027 6 back-to-back jobs during WAIT -> first 4 accepted, job_ready=0 at fifo_count=4; in RUN issued on 4 consecutive cycles in order with correct op; remaining 2 accepted as space frees.
REQ-028 New key 0xffff...ff in RUN with empty FIFO -> 11 INVALID cycles, eng_halt one cycle, eng_set_key next cycle, then the priming job.
REQ-029 rst during RUN with fifo_count=3 -> next cycle fifo_count=0, IDLE, eng_in_type=INVALID, and no issue of the queued jobs.
REQ-030 With AES_FEEDER_JOBCNT_EN, 5 jobs after a key load -> jobs_issued=5; without the macro -> jobs_issued=0.
